// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and forward-select encoding for the hazard controller
package hazard_pkg;

  localparam int FWD_RF = 0;

  // Select value for forwarding stage k; stage NFWD stands for the long-unit result bus.
  function automatic int unsigned fwd_enc(input int unsigned stage);
    return stage + 1;
  endfunction

  function automatic int unsigned sel_width(input int unsigned nfwd);
    return $clog2(nfwd + 2);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand forwarding priority match, ready check and select
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter  int AW   = 5,
  parameter  int NFWD = 2,
  localparam int SW   = sel_width(NFWD)
) (
  input  logic               id_valid,
  input  logic               use_rs,
  input  logic [AW-1:0]      rs,
  input  logic [NFWD*AW-1:0] fwd_rd,
  input  logic [NFWD-1:0]    fwd_wen,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic               lu_done,
  input  logic [AW-1:0]      lu_done_rd,
  output logic [SW-1:0]      sel,
  output logic               not_ready
);

  logic hit;

  always_comb begin
    sel       = SW'(FWD_RF);
    not_ready = 1'b0;
    hit       = 1'b0;
    if (id_valid && rs != '0) begin
      // Walk oldest to youngest so the youngest matching stage is the last writer.
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_wen[k] && fwd_rd[k*AW +: AW] == rs) begin
          sel       = SW'(fwd_enc($unsigned(k)));
          not_ready = use_rs & ~fwd_ready[k];
          hit       = 1'b1;
        end
      end
      if (!hit && lu_done && lu_done_rd == rs) begin
        sel = SW'(fwd_enc($unsigned(NFWD)));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard/forwarding controller with long-latency scoreboard
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int AW      = 5,
  parameter  int NFWD    = 2,
  parameter  int MAX_OUT = 4,
  localparam int SW      = sel_width(NFWD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [AW-1:0]      id_rs1,
  input  logic [AW-1:0]      id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_wen,
  input  logic               id_long,
  input  logic [NFWD*AW-1:0] fwd_rd,
  input  logic [NFWD-1:0]    fwd_wen,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic               lu_done,
  input  logic [AW-1:0]      lu_done_rd,
  input  logic               flush,
  output logic               pc_write,
  output logic               id_write,
  output logic               ctrl_bubble,
  output logic [SW-1:0]      fwd_sel_a,
  output logic [SW-1:0]      fwd_sel_b,
  output logic               sb_full,
  output logic               sb_err,
  output logic [31:0]        stall_cnt
);

  localparam int NREG = 2 ** AW;
  localparam int OW   = $clog2(MAX_OUT + 1);

  logic [NREG-1:0] pending;
  logic [OW-1:0]   outstanding;

  logic use_a, use_b, nr_a, nr_b;
  logic raw_a, raw_b, waw, structural, stall;
  logic lu_valid, issue;

  assign use_a = id_valid & id_use_rs1;
  assign use_b = id_valid & id_use_rs2;

  hazard_fwd_sel #(.AW(AW), .NFWD(NFWD)) u_sel_a (
    .id_valid   (id_valid),
    .use_rs     (use_a),
    .rs         (id_rs1),
    .fwd_rd     (fwd_rd),
    .fwd_wen    (fwd_wen),
    .fwd_ready  (fwd_ready),
    .lu_done    (lu_done),
    .lu_done_rd (lu_done_rd),
    .sel        (fwd_sel_a),
    .not_ready  (nr_a)
  );

  hazard_fwd_sel #(.AW(AW), .NFWD(NFWD)) u_sel_b (
    .id_valid   (id_valid),
    .use_rs     (use_b),
    .rs         (id_rs2),
    .fwd_rd     (fwd_rd),
    .fwd_wen    (fwd_wen),
    .fwd_ready  (fwd_ready),
    .lu_done    (lu_done),
    .lu_done_rd (lu_done_rd),
    .sel        (fwd_sel_b),
    .not_ready  (nr_b)
  );

  // A writeback this cycle resolves the hazard: the value arrives on the result bus.
  assign raw_a = use_a & pending[id_rs1] & ~(lu_done && lu_done_rd == id_rs1);
  assign raw_b = use_b & pending[id_rs2] & ~(lu_done && lu_done_rd == id_rs2);
  assign waw   = id_valid & id_wen & (id_rd != '0) & pending[id_rd]
               & ~(lu_done && lu_done_rd == id_rd);

  assign lu_valid   = lu_done & pending[lu_done_rd];
  assign sb_full    = (outstanding == OW'(MAX_OUT));
  assign structural = id_valid & id_long & sb_full & ~lu_valid;

  assign stall       = nr_a | nr_b | raw_a | raw_b | waw | structural;
  assign issue       = id_valid & ~stall & id_long;
  assign pc_write    = ~stall;
  assign id_write    = ~stall;
  assign ctrl_bubble = stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
      sb_err      <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (lu_done && !pending[lu_done_rd]) begin
        sb_err <= 1'b1;
      end
      if (flush) begin
        pending     <= '0;
        outstanding <= '0;
      end else begin
        // The set is written after the clear so a same-register collision keeps the bit.
        if (lu_valid) begin
          pending[lu_done_rd] <= 1'b0;
        end
        if (issue && id_wen && id_rd != '0) begin
          pending[id_rd] <= 1'b1;
        end
        if (issue && !lu_valid && !sb_full) begin
          outstanding <= outstanding + OW'(1);
        end else if (lu_valid && !issue && outstanding != '0) begin
          outstanding <= outstanding - OW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int NFWD = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_use_rs1, id_use_rs2, id_wen, id_long;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd, lu_done_rd;
  logic [2*AW-1:0] fwd_rd;
  logic [1:0]      fwd_wen, fwd_ready;
  logic            lu_done, flush;
  logic            pc_write, id_write, ctrl_bubble, sb_full, sb_err;
  logic [SW-1:0]   fwd_sel_a, fwd_sel_b;
  logic [31:0]     stall_cnt;

  hazard_scoreboard #(.AW(AW), .NFWD(NFWD), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_long(id_long), .fwd_rd(fwd_rd), .fwd_wen(fwd_wen), .fwd_ready(fwd_ready),
    .lu_done(lu_done), .lu_done_rd(lu_done_rd), .flush(flush), .pc_write(pc_write),
    .id_write(id_write), .ctrl_bubble(ctrl_bubble), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .sb_full(sb_full), .sb_err(sb_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic wen; logic lng;
    logic [4:0] f0; logic [4:0] f1; logic [1:0] fwen; logic [1:0] frdy;
    logic lud; logic [4:0] lurd; logic fl; logic rstn;
    logic e_stall; logic [1:0] e_sa; logic [1:0] e_sb;
    logic e_full; logic e_err; logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    int idx; logic stall; logic [1:0] sa; logic [1:0] sb;
    logic full; logic err; logic [31:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   vidx  = 0;

  function automatic vec_t vec(
    input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic wen, input logic lng,
    input logic [4:0] f0, input logic [4:0] f1, input logic [1:0] fwen, input logic [1:0] frdy,
    input logic lud, input logic [4:0] lurd, input logic fl, input logic rstn,
    input logic e_stall, input logic [1:0] e_sa, input logic [1:0] e_sb,
    input logic e_full, input logic e_err, input logic [31:0] e_cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd; r.wen = wen;
    r.lng = lng; r.f0 = f0; r.f1 = f1; r.fwen = fwen; r.frdy = frdy; r.lud = lud;
    r.lurd = lurd; r.fl = fl; r.rstn = rstn; r.e_stall = e_stall; r.e_sa = e_sa;
    r.e_sb = e_sb; r.e_full = e_full; r.e_err = e_err; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    exp_t e;
    id_valid = t.v; id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_wen = t.wen; id_long = t.lng; fwd_rd = {t.f1, t.f0};
    fwd_wen = t.fwen; fwd_ready = t.frdy; lu_done = t.lud; lu_done_rd = t.lurd;
    flush = t.fl; rst_n = t.rstn;
    e.idx = vidx; e.stall = t.e_stall; e.sa = t.e_sa; e.sb = t.e_sb;
    e.full = t.e_full; e.err = t.e_err; e.cnt = t.e_cnt;
    expq.push_back(e);
    vidx++;
  endtask

  task automatic check_one();
    exp_t e;
    logic ok;
    e = expq.pop_front();
    tests++;
    ok = (ctrl_bubble === e.stall) && (pc_write === ~e.stall) && (id_write === ~e.stall)
      && (fwd_sel_a === e.sa) && (fwd_sel_b === e.sb) && (sb_full === e.full)
      && (sb_err === e.err) && (stall_cnt === e.cnt);
    if (!ok) begin
      fails++;
      $display("FAIL vec%0d: got bubble=%b pcw=%b idw=%b sa=%0d sb=%0d full=%b err=%b cnt=%0d, want bubble=%b sa=%0d sb=%0d full=%b err=%b cnt=%0d",
               e.idx, ctrl_bubble, pc_write, id_write, fwd_sel_a, fwd_sel_b, sb_full, sb_err,
               stall_cnt, e.stall, e.sa, e.sb, e.full, e.err, e.cnt);
    end
  endtask

  task automatic step(input vec_t t);
    drive(t);
    @(negedge clk);
    check_one();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         v rs1 u1 rs2 u2 rd wen lng f0 f1 fwen   frdy   lud lurd fl rn  stl sa sb fu er cnt
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, 5, 1, 0, 0, 0, 0, 0, 5, 0, 2'b01, 2'b11, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, 6, 1, 6, 1, 0, 0, 0, 6, 6, 2'b11, 2'b11, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(vec(1, 0, 0, 8, 1, 0, 0, 0, 0, 8, 2'b10, 2'b11, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0));
    // load-use: one bubble, then stage 1 forwards
    tbl.push_back(vec(1, 0, 0, 7, 1, 0, 0, 0, 7, 0, 2'b01, 2'b10, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(vec(1, 0, 0, 7, 1, 0, 0, 0, 0, 7, 2'b10, 2'b11, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
    tbl.push_back(vec(1, 0, 0, 7, 0, 0, 0, 0, 7, 0, 2'b01, 2'b10, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    // div to x9, consumer waits for writeback
    tbl.push_back(vec(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2));
    tbl.push_back(vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1, 9, 0, 1, 0, 3, 0, 0, 0, 3));
    tbl.push_back(vec(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    // fill the scoreboard
    for (int r = 1; r <= 4; r++)
      tbl.push_back(vec(1, 0, 0, 0, 0, 5'(r), 1, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(vec(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0, 0, 1, 0, 3));
    tbl.push_back(vec(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 2'b00, 2'b11, 1, 1, 0, 1, 0, 0, 0, 1, 0, 4));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1, 1, 0, 0, 0, 1, 0, 4));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    // x12 same-cycle set/clear, spurious done, flush
    tbl.push_back(vec(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(vec(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 2'b00, 2'b11, 1, 12, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1, 3, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(vec(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0, 0, 0, 1, 4));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 1, 1, 0, 0, 0, 0, 1, 5));
    tbl.push_back(vec(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5));
    // WAW against a pending long op
    tbl.push_back(vec(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5));
    tbl.push_back(vec(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0, 0, 0, 1, 5));
    tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6));

    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
    id_wen = 0; id_long = 0; fwd_rd = 0; fwd_wen = 0; fwd_ready = 2'b11;
    lu_done = 0; lu_done_rd = 0; flush = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i]);

    // reset asserted while the consumer of x13 is stalled
    step(vec(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 1, 6));
    step(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(vec(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d left, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the RISC-V pipeline. It replaces fixed EX/MEM forwarding and single-case load-use detection with three parts: N-stage forwarding selection, a generalised not-ready stall, and a per-register scoreboard for an out-of-order long-latency unit (mul/div). It sits beside the ID stage. It drives the PC/IF-ID write enables, the ID/EX bubble select and the operand mux selects.

## Interface
Parameters:
- AW, 5, register index width; NREG = 2**AW
- NFWD, 2, forwarding stages after ID; index 0 = youngest (EX)
- MAX_OUT, 4, maximum outstanding long-latency ops
- SW, $clog2(NFWD+2), forward-select width (derived, localparam)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  AW  source indices
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  AW  destination index
- id_wen  in  1  instruction writes rd
- id_long  in  1  instruction issues to the long-latency unit
- fwd_rd  in  NFWD*AW  per-stage destination, stage k at bits [k*AW +: AW]
- fwd_wen  in  NFWD  per-stage register write
- fwd_ready  in  NFWD  per-stage result available (0 = load still in flight)
- lu_done  in  1  long unit writes back this cycle
- lu_done_rd  in  AW  its destination
- flush  in  1  kill all outstanding long ops
- pc_write  out  1  PC write enable
- id_write  out  1  IF/ID write enable
- ctrl_bubble  out  1  insert NOP controls into ID/EX
- fwd_sel_a, fwd_sel_b  out  SW  0 = register file, k+1 = stage k, NFWD+1 = long-unit result bus
- sb_full  out  1  outstanding == MAX_OUT
- sb_err  out  1  sticky: lu_done for a register that was not pending
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Register x0 never creates a hazard, is never tracked, and is never forwarded.
- Forward select per operand:
  - Pick the youngest stage k with fwd_wen[k] and fwd_rd[k]==rs, giving select k+1.
  - Otherwise, if lu_done and lu_done_rd==rs, select NFWD+1.
  - Otherwise select 0.
- Stall conditions (any one stalls). A source only counts when id_valid and its id_use_* bit is set.
  - Not-ready: the youngest matching stage has fwd_ready=0.
  - RAW-pending: pending[rs]=1 and not (lu_done & lu_done_rd==rs).
  - WAW: id_wen and pending[id_rd]=1 and not cleared this cycle by lu_done.
  - Structural: id_long and outstanding==MAX_OUT and no lu_done this cycle.
- On stall: pc_write=0, id_write=0, ctrl_bubble=1. Otherwise pc_write=1, id_write=1, ctrl_bubble=0.
- Define fire = id_valid & ~stall.
- pending[] updates:
  - A long op that fires with id_wen and rd≠0 sets pending[id_rd].
  - lu_done clears pending[lu_done_rd].
  - If set and clear hit the same register in the same cycle, set wins.
- outstanding counter:
  - Increments on a long op that fires.
  - Decrements on a valid lu_done (target was pending).
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT and never drops below 0.
- lu_done with pending[lu_done_rd]=0: sets sb_err; pending and outstanding are unchanged.
- flush clears all pending bits and outstanding to 0 at the next edge. It overrides issue and done in the same cycle. sb_err is unaffected.
- stall_cnt increments every stall cycle and saturates at 2^32−1.

## Timing
- Outputs are combinational from inputs and current state. There is zero-cycle latency from ID inputs to stall and selects.
- State (pending, outstanding, sb_err, stall_cnt) updates on the rising clk edge.
- rst_n low at an edge clears all state to 0, mid-operation included. After that edge: sb_full=0, sb_err=0, stall_cnt=0. With id_valid=0 the outputs are pc_write=1, id_write=1, ctrl_bubble=0 and fwd_sel=0.
- A long op that fires in cycle t is visible as pending from t+1.
- A consumer in ID during the lu_done cycle does not stall and receives select NFWD+1.
- Load-use (NFWD=2, load in EX not ready): exactly 1 stall cycle. In the next cycle the load is in stage 1 with fwd_ready=1 and the select is 2.

## Structure
- Package hazard_pkg holds the FWD_RF=0 constant and the select-encoding helper function. Its width is derived from NFWD.
- Sub-module hazard_fwd_sel handles one operand: priority match, ready check and select. It is instantiated twice, for rs1 and rs2.
- The scoreboard registers, counters and stall combine live in the top level.

## Test plan
- ALU chain: add x5 in stage 0 (ready), consumer rs1=x5 → fwd_sel_a=1, no stall. Same with rs1=x0 and fwd_rd[0]=0 → fwd_sel_a=0.
- Load-use: fwd_rd[0]=x7, fwd_ready[0]=0, rs2=x7 → one cycle with pc_write=0, ctrl_bubble=1. Next cycle fwd_sel_b=2, stall_cnt=1.
- Long op: div to x9 fires, consumer of x9 → stalls until lu_done with lu_done_rd=9. In that cycle: no stall, fwd_sel_a=3, outstanding back to 0.
- Full: 4 long ops issued, a 5th stalls with sb_full=1. lu_done in the same cycle releases it and the count stays 4.
- Same-cycle set/clear on x12, then a spurious lu_done for x3 → pending[12] remains 1 and sb_err=1. flush → sb_full=0 and the x12 consumer no longer stalls.
- Reset mid-stall: rst_n=0 for one edge → stall_cnt=0, all pending cleared, no stall with id_valid=0.
